// File: rtl/fsk_pkg.sv
// fsk_pkg
// Shared definitions for the FSK demodulator controller: the FSM state
// encoding, the smallest divider the sample timer will run with, and the
// default energy-wait timeout.
package fsk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DUMP,
    S_WAIT_E,
    S_DECIDE
  } fsk_state_t;

  // Dividers below this are raised to it so the DUMP/WAIT_E/DECIDE sequence
  // always finishes before the next sample strobe of the following symbol.
  localparam int MIN_DIV = 20;

  // Cycles from the accumulator dump pulse to the timeout error pulse.
  localparam int TMO_DEFAULT = 16;

endpackage

// File: rtl/fsk_sample_timer.sv
// fsk_sample_timer
// Sample-rate divider and samples-per-symbol counter.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              latch (clamped) cfg_div/cfg_sps and clear both counters
//   active            controller is not idle; the divider runs only then
//   in_run            controller is in RUN; only then do samples advance smp_cnt
//   cfg_div, cfg_sps  configuration, sampled on load
//   sample_en         one-cycle strobe on the last cycle of each divider period
//   smp_cnt           index of the current sample within the symbol
//   last_smp          smp_cnt addresses the final sample of the symbol
module fsk_sample_timer
  import fsk_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int SPS_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             active,
  input  logic             in_run,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [SPS_W-1:0] cfg_sps,
  output logic             sample_en,
  output logic [SPS_W-1:0] smp_cnt,
  output logic             last_smp
);

  logic [DIV_W-1:0] div_q;
  logic [SPS_W-1:0] sps_q;
  logic [DIV_W-1:0] div_cnt;

  // The divider keeps counting through DUMP/WAIT_E/DECIDE so the symbol
  // period stays exactly div*sps cycles; it is held at zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= DIV_W'(MIN_DIV);
      sps_q   <= SPS_W'(1);
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (load) begin
      div_q   <= (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
      sps_q   <= (cfg_sps == '0) ? SPS_W'(1) : cfg_sps;
      div_cnt <= '0;
      smp_cnt <= '0;
    end else if (!active) begin
      div_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      div_cnt <= sample_en ? '0 : div_cnt + DIV_W'(1);
      if (in_run && sample_en)
        smp_cnt <= last_smp ? '0 : smp_cnt + SPS_W'(1);
    end
  end

  assign sample_en = active && (div_cnt == div_q - DIV_W'(1));
  assign last_smp  = (smp_cnt == sps_q - SPS_W'(1));

endmodule

// File: rtl/fsk_demod_ctrl.sv
// fsk_demod_ctrl
// Control FSM for a two-tone (FSK) correlator demodulator. It paces the
// ADC/correlator with a sample strobe and table address, dumps and clears the
// correlator accumulators once per symbol, waits for the two tone energies and
// turns them into a bit.
// Ports:
//   clk, reset                clock, synchronous active-high reset
//   start                     level; starts demodulation when seen in IDLE
//   stop                      pulse; stop after the current symbol completes
//   cfg_div, cfg_sps          clock cycles per sample, samples per symbol
//   energy_f1, energy_f2      unsigned correlator energies for tones f1/f2
//   energy_valid              energies are valid this cycle
//   sample_en, rom_addr       sample strobe and reference-table index
//   acc_clr, acc_dump         correlator accumulator clear / dump pulses
//   bit_out, bit_valid        decided bit (1 = f2 stronger) and its strobe
//   busy, err                 not idle; one-cycle energy timeout pulse
module fsk_demod_ctrl
  import fsk_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int SPS_W = 7,
  parameter int E_W   = 24,
  parameter int TMO   = TMO_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [SPS_W-1:0] cfg_sps,
  input  logic [E_W-1:0]   energy_f1,
  input  logic [E_W-1:0]   energy_f2,
  input  logic             energy_valid,
  output logic             sample_en,
  output logic [SPS_W-1:0] rom_addr,
  output logic             acc_clr,
  output logic             acc_dump,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             err
);

  localparam int TMO_W = $clog2(TMO + 1);
  // The timeout counter starts in the first WAIT_E cycle, so leaving on
  // TMO-2 puts the err pulse exactly TMO cycles after the acc_dump pulse.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 2);

  fsk_state_t       state;
  logic             stop_pending;
  logic [TMO_W-1:0] tmo_cnt;
  logic [E_W-1:0]   e1_q;
  logic [E_W-1:0]   e2_q;
  logic             last_smp;
  logic             load;

  assign load = (state == S_IDLE) && start;
  assign busy = (state != S_IDLE);

  fsk_sample_timer #(
    .DIV_W (DIV_W),
    .SPS_W (SPS_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .active    (busy),
    .in_run    (state == S_RUN),
    .cfg_div   (cfg_div),
    .cfg_sps   (cfg_sps),
    .sample_en (sample_en),
    .smp_cnt   (rom_addr),
    .last_smp  (last_smp)
  );

  // Symbol sequencing. All pulse outputs are registered and therefore appear
  // in the first cycle of the state that follows the transition causing them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      stop_pending <= 1'b0;
      tmo_cnt      <= '0;
      e1_q         <= '0;
      e2_q         <= '0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      acc_clr      <= 1'b0;
      acc_dump     <= 1'b0;
      err          <= 1'b0;
    end else begin
      acc_clr   <= 1'b0;
      acc_dump  <= 1'b0;
      bit_valid <= 1'b0;
      err       <= 1'b0;

      if (state != S_IDLE && stop)
        stop_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            acc_clr <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (sample_en && last_smp) begin
            acc_dump <= 1'b1;
            state    <= S_DUMP;
          end
        end
        S_DUMP: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_E;
        end
        S_WAIT_E: begin
          if (energy_valid) begin
            e1_q  <= energy_f1;
            e2_q  <= energy_f2;
            state <= S_DECIDE;
          end else if (tmo_cnt == TMO_LAST) begin
            err          <= 1'b1;
            stop_pending <= 1'b0;
            state        <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DECIDE: begin
          // Equal energies carry no information, so the previous bit is kept.
          if (e2_q > e1_q)
            bit_out <= 1'b1;
          else if (e1_q > e2_q)
            bit_out <= 1'b0;
          bit_valid <= 1'b1;
          acc_clr   <= 1'b1;
          if (stop_pending || stop) begin
            stop_pending <= 1'b0;
            state        <= S_IDLE;
          end else begin
            state <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_demod_ctrl.sv
// tb_fsk_demod_ctrl
// Self-checking bench for fsk_demod_ctrl. Expected outputs come from a
// timeline model: strobes fall on multiples of the clamped divider counted
// from the first RUN cycle, each symbol dumps one cycle after its last
// strobe, and the decided bit appears two cycles after the energies arrive.
module tb_fsk_demod_ctrl;

  localparam int DIV_W = 16;
  localparam int SPS_W = 7;
  localparam int E_W   = 24;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] cfg_div;
  logic [SPS_W-1:0] cfg_sps;
  logic [E_W-1:0]   energy_f1;
  logic [E_W-1:0]   energy_f2;
  logic             energy_valid;
  logic             sample_en;
  logic [SPS_W-1:0] rom_addr;
  logic             acc_clr;
  logic             acc_dump;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             err;

  logic [13:0] obs;
  assign obs = {sample_en, rom_addr, acc_clr, acc_dump, bit_out, bit_valid, busy, err};

  int   checks = 0;
  int   fails  = 0;
  logic ref_bit;
  int   e1_tab[8];
  int   e2_tab[8];
  int   dly_tab[8];

  always #5 clk = ~clk;

  fsk_demod_ctrl #(
    .DIV_W (DIV_W),
    .SPS_W (SPS_W),
    .E_W   (E_W),
    .TMO   (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .cfg_div      (cfg_div),
    .cfg_sps      (cfg_sps),
    .energy_f1    (energy_f1),
    .energy_f2    (energy_f2),
    .energy_valid (energy_valid),
    .sample_en    (sample_en),
    .rom_addr     (rom_addr),
    .acc_clr      (acc_clr),
    .acc_dump     (acc_dump),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .err          (err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held with random inputs, then a quiet idle: everything reads zero.
  task automatic test_reset();
    reset        = 1'b1;
    start        = 1'($urandom);
    stop         = 1'($urandom);
    energy_valid = 1'($urandom);
    cfg_div      = DIV_W'($urandom);
    cfg_sps      = SPS_W'($urandom);
    energy_f1    = E_W'($urandom);
    energy_f2    = E_W'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 14'd0) begin
        fails++;
        $display("[TB] FAIL reset_hold cycle=%0d: got %b, expected %b", i, obs, 14'd0);
      end
    end
    reset        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    energy_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 14'd0) begin
        fails++;
        $display("[TB] FAIL idle_after_reset cycle=%0d: got %b, expected %b", i, obs, 14'd0);
      end
    end
    ref_bit = 1'b0;
  endtask

  // One start-to-idle session of nsym symbols, checked every cycle. The
  // session ends either by a stop pulse inside the last symbol or by
  // withholding the last symbol's energies so it times out.
  task automatic test_stream(input int div_cfg, input int sps_cfg, input int nsym,
                             input bit timeout_end, input bit rand_tab, input string tag);
    int div, sps, total;
    int tdump[8], tev[8], tbv[8];
    int end_busy, stop_t, terr, nstrobe, exp_rom;
    logic exp_se, exp_dump, exp_bv, exp_clr, exp_err, exp_busy;
    logic [13:0] exp_v;

    div   = (div_cfg < 20) ? 20 : div_cfg;
    sps   = (sps_cfg == 0) ? 1 : sps_cfg;
    total = nsym * sps;
    for (int j = 0; j < nsym; j++) begin
      if (rand_tab) begin
        e1_tab[j]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom & 32'h00FF_FFFF);
        e2_tab[j]  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom & 32'h00FF_FFFF);
        dly_tab[j] = $urandom_range(1, 12);
      end
      tdump[j] = (j + 1) * sps * div + 1;
      tev[j]   = tdump[j] + dly_tab[j];
      tbv[j]   = tev[j] + 2;
    end
    if (timeout_end) begin
      terr     = tdump[nsym-1] + TMO;
      end_busy = terr;
      stop_t   = -1;
    end else begin
      terr     = -1;
      end_busy = tbv[nsym-1];
      stop_t   = $urandom_range((nsym - 1) * sps * div + 20, nsym * sps * div);
    end

    // A stop seen while idle must be ignored.
    stop         = 1'b1;
    start        = 1'b0;
    energy_valid = 1'b0;
    tick();
    stop    = 1'b0;
    start   = 1'b1;
    cfg_div = DIV_W'(div_cfg);
    cfg_sps = SPS_W'(sps_cfg);
    tick();

    for (int t = 1; t <= end_busy + 3; t++) begin
      exp_se  = (t % div == 0) && (t / div <= total);
      nstrobe = (t - 1) / div;
      if (nstrobe > total) nstrobe = total;
      exp_rom  = nstrobe % sps;
      exp_dump = 1'b0;
      exp_bv   = 1'b0;
      for (int j = 0; j < nsym; j++) begin
        if (t == tdump[j]) exp_dump = 1'b1;
        if (!(timeout_end && j == nsym - 1) && t == tbv[j]) begin
          exp_bv = 1'b1;
          if (e2_tab[j] > e1_tab[j]) ref_bit = 1'b1;
          else if (e1_tab[j] > e2_tab[j]) ref_bit = 1'b0;
        end
      end
      exp_clr  = (t == 1) || exp_bv;
      exp_err  = (t == terr);
      exp_busy = (t < end_busy);
      exp_v    = {exp_se, SPS_W'(exp_rom), exp_clr, exp_dump, ref_bit, exp_bv, exp_busy, exp_err};
      checks++;
      if (obs !== exp_v) begin
        fails++;
        $display("[TB] FAIL %s t=%0d: got %b, expected %b (se,rom[7],clr,dump,bit,bv,busy,err)",
                 tag, t, obs, exp_v);
      end

      // Inputs for this cycle; config is scrambled after it has been latched.
      start = (t < 4);
      if (t == 1) begin
        cfg_div = DIV_W'($urandom_range(0, 100));
        cfg_sps = SPS_W'($urandom);
      end
      stop         = (t == stop_t);
      energy_valid = 1'b0;
      energy_f1    = E_W'($urandom);
      energy_f2    = E_W'($urandom);
      for (int j = 0; j < nsym; j++) begin
        if (!(timeout_end && j == nsym - 1) && t == tev[j]) begin
          energy_valid = 1'b1;
          energy_f1    = E_W'(e1_tab[j]);
          energy_f2    = E_W'(e2_tab[j]);
        end
      end
      tick();
    end
    start        = 1'b0;
    stop         = 1'b0;
    energy_valid = 1'b0;
  endtask

  // Reset in the middle of RUN drops every output on the next cycle.
  task automatic test_reset_mid_run();
    cfg_div      = DIV_W'(20);
    cfg_sps      = SPS_W'(4);
    stop         = 1'b0;
    energy_valid = 1'b0;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (36) tick();
    checks++;
    if (busy !== 1'b1 || rom_addr !== SPS_W'(1)) begin
      fails++;
      $display("[TB] FAIL mid_run_state: got busy=%b rom=%0d, expected busy=1 rom=1", busy, rom_addr);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 14'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_run: got %b, expected %b", obs, 14'd0);
    end
    reset   = 1'b0;
    ref_bit = 1'b0;
    tick();
    checks++;
    if (obs !== 14'd0) begin
      fails++;
      $display("[TB] FAIL idle_after_mid_reset: got %b, expected %b", obs, 14'd0);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    energy_valid = 1'b0;
    cfg_div      = '0;
    cfg_sps      = '0;
    energy_f1    = '0;
    energy_f2    = '0;
    ref_bit      = 1'b0;

    test_reset();

    // f1 wins, f2 wins, then a tie that must keep the 1.
    e1_tab[0] = 1000; e2_tab[0] = 500;  dly_tab[0] = 3;
    e1_tab[1] = 500;  e2_tab[1] = 1000; dly_tab[1] = 3;
    e1_tab[2] = 700;  e2_tab[2] = 700;  dly_tab[2] = 3;
    test_stream(800, 10, 3, 1'b0, 1'b0, "div800_sps10");

    test_reset_mid_run();
    test_stream(5, 3, 1, 1'b0, 1'b1, "stop_div5");
    test_stream(20, 2, 2, 1'b1, 1'b1, "timeout");
    test_stream(30, 0, 3, 1'b0, 1'b1, "sps0");
    for (int k = 0; k < 5; k++)
      test_stream($urandom_range(0, 60), $urandom_range(0, 6), $urandom_range(1, 4),
                  1'($urandom_range(0, 1)), 1'b1, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
